// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port block-RAM arbiter: port count, response-slot states, tie-break helper.
package bram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    HOLD     = 2'd2
  } slot_state_t;

  // cand[i] = port i is valid and eligible; prefer1 decides a tie toward port 1.
  function automatic logic [1:0] pick_grant(input logic [1:0] cand, input logic prefer1);
    logic [1:0] g;
    if (cand == 2'b11) begin
      g = prefer1 ? 2'b10 : 2'b01;
    end else begin
      g = cand;
    end
    return g;
  endfunction

endpackage

// File: rtl/bram_arb_checker.sv
// Simulation-only protocol checks for the arbiter: RAM DO_VALID tracks outstanding accesses, grants are exclusive.
module bram_arb_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       ram_do_valid,
  input logic [1:0] inflight,
  input logic [1:0] grant
);

  a_do_valid_matches: assert property (@(posedge clk) disable iff (!rst_n)
    ram_do_valid == (inflight[0] | inflight[1]));

  a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(grant[0] && grant[1]));

endmodule

// File: rtl/bram_arb_rsp_slot.sv
// Per-port response slot: tracks the outstanding access, parks the RAM word when the requester stalls,
// and presents the response (live RAM output or parked word).
module bram_arb_rsp_slot
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant,
  input  logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  eligible,
  output logic                  inflight,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  slot_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  // Next-state and hold capture; a stalled fresh response is copied out of the RAM before it is overwritten.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = INFLIGHT;
        else       state_d = IDLE;
      end
      INFLIGHT: begin
        if (grant) begin
          state_d = INFLIGHT;
        end else if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          hold_d  = ram_do;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_d = IDLE;
          hold_d  = {DATA_WIDTH{1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Slot state and hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Response presentation and eligibility for a new grant.
  always_comb begin
    eligible  = 1'b0;
    inflight  = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = {DATA_WIDTH{1'b0}};
    case (state_q)
      IDLE: begin
        eligible = 1'b1;
      end
      INFLIGHT: begin
        eligible  = rsp_ready;
        inflight  = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = ram_do;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        rsp_rdata = hold_q;
      end
      default: begin
        eligible = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a one-cycle block RAM (port 0 = fetch, port 1 = load/store).
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 1 always wins a tie.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_do,
  input  logic                  ram_do_valid
);

  logic [NUM_PORTS-1:0] elig_s;
  logic [NUM_PORTS-1:0] inflight_s;
  logic [NUM_PORTS-1:0] cand_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic                 prefer1_s;

  // Gating with RST_N keeps every output at zero while reset is held.
  assign cand_s = {req1_valid & elig_s[1], req0_valid & elig_s[0]} & {2{RST_N}};

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Remember the most recent winner; idle cycles leave it untouched.
  always_comb begin
    if (grant_s[1]) begin
      last_d = 1'b1;
    end else if (grant_s[0]) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
  end

  // Starts at 1 so port 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign prefer1_s = (last_q == 1'b0);
`else
  assign prefer1_s = 1'b1;
`endif

  assign grant_s    = pick_grant(cand_s, prefer1_s);
  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // RAM request mux: the winner drives both address ports; idle cycles present zeros.
  always_comb begin
    ram_wr_addr = {ADDR_WIDTH{1'b0}};
    ram_rd_addr = {ADDR_WIDTH{1'b0}};
    ram_di      = {DATA_WIDTH{1'b0}};
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    if (grant_s[0]) begin
      ram_wr_addr = req0_addr;
      ram_rd_addr = req0_addr;
      ram_di      = req0_wdata;
      ram_we      = req0_write;
      ram_re      = 1'b1;
    end else if (grant_s[1]) begin
      ram_wr_addr = req1_addr;
      ram_rd_addr = req1_addr;
      ram_di      = req1_wdata;
      ram_we      = req1_write;
      ram_re      = 1'b1;
    end else begin
      ram_re      = 1'b0;
    end
  end

  bram_arb_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .grant     (grant_s[0]),
    .rsp_ready (rsp0_ready),
    .ram_do    (ram_do),
    .eligible  (elig_s[0]),
    .inflight  (inflight_s[0]),
    .rsp_valid (rsp0_valid),
    .rsp_rdata (rsp0_rdata)
  );

  bram_arb_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .grant     (grant_s[1]),
    .rsp_ready (rsp1_ready),
    .ram_do    (ram_do),
    .eligible  (elig_s[1]),
    .inflight  (inflight_s[1]),
    .rsp_valid (rsp1_valid),
    .rsp_rdata (rsp1_rdata)
  );

  bram_arb_checker u_checker (
    .clk          (CLK),
    .rst_n        (RST_N),
    .ram_do_valid (ram_do_valid),
    .inflight     (inflight_s),
    .grant        (grant_s)
  );

endmodule
